// File: rtl/preddr_capture_sequencer.sv
// preddr_capture_sequencer
// Sequences a segmented ADC capture into the pre-DDR FIFO: arm, wait for
// trigger, write cfg_samples samples per segment for cfg_segments segments,
// then signal completion and hold off for the converter's filler writes.
module preddr_capture_sequencer #(
    parameter int pCOUNT_WIDTH = 20,
    parameter int pHOLDOFF     = 16
) (
    input  logic                    wr_clk,
    input  logic                    reset,
    input  logic                    arm_i,
    input  logic                    trigger_i,
    input  logic                    abort_i,
    input  logic                    adc_valid_i,
    input  logic                    fifo_full_i,
    input  logic [pCOUNT_WIDTH-1:0] cfg_samples,
    input  logic [15:0]             cfg_segments,
    output logic                    capture_start,
    output logic                    capture_done,
    output logic                    O_wr,
    output logic                    armed,
    output logic                    busy,
    output logic                    cfg_error,
    output logic                    full_error,
    output logic [pCOUNT_WIDTH-1:0] sample_count,
    output logic [15:0]             segment_count
);

    localparam int HOLD_W = (pHOLDOFF > 1) ? $clog2(pHOLDOFF) : 1;
    localparam logic [HOLD_W-1:0]       HOLD_LAST = HOLD_W'(pHOLDOFF - 1);
    localparam logic [HOLD_W-1:0]       HOLD_ONE  = HOLD_W'(1);
    localparam logic [pCOUNT_WIDTH-1:0] SAMP_ZERO = {pCOUNT_WIDTH{1'b0}};
    localparam logic [pCOUNT_WIDTH-1:0] SAMP_MAX  = {pCOUNT_WIDTH{1'b1}};
    localparam logic [pCOUNT_WIDTH-1:0] SAMP_ONE  = pCOUNT_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_REARM   = 3'd3,
        ST_DONE    = 3'd4,
        ST_HOLDOFF = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [pCOUNT_WIDTH-1:0] sample_count_q, sample_count_d;
    logic [15:0]             segment_count_q, segment_count_d;
    logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic                    capture_start_q, capture_start_d;
    logic                    capture_done_q, capture_done_d;
    logic                    o_wr_q, o_wr_d;
    logic                    armed_q, armed_d;
    logic                    busy_q, busy_d;
    logic                    cfg_error_q, cfg_error_d;
    logic                    full_error_q, full_error_d;

    logic                    cfg_ok_s;
    logic [pCOUNT_WIDTH-1:0] samp_inc_s;
    logic [15:0]             seg_inc_s;

    // Counters saturate instead of wrapping if the configuration shrinks mid-capture.
    assign samp_inc_s = (sample_count_q == SAMP_MAX) ? sample_count_q : sample_count_q + SAMP_ONE;
    assign seg_inc_s  = (segment_count_q == 16'hFFFF) ? segment_count_q : segment_count_q + 16'd1;
    assign cfg_ok_s   = (cfg_samples != SAMP_ZERO) && (cfg_segments != 16'd0);

    // Next-state and next-output decode for the capture sequencer.
    always_comb begin
        state_d         = state_q;
        sample_count_d  = sample_count_q;
        segment_count_d = segment_count_q;
        hold_cnt_d      = hold_cnt_q;
        cfg_error_d     = cfg_error_q;
        full_error_d    = full_error_q;
        capture_start_d = 1'b0;
        capture_done_d  = 1'b0;
        o_wr_d          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm_i) begin
                    if (cfg_ok_s) begin
                        capture_start_d = 1'b1;
                        sample_count_d  = SAMP_ZERO;
                        segment_count_d = 16'd0;
                        full_error_d    = 1'b0;
                        cfg_error_d     = 1'b0;
                        state_d         = ST_ARMED;
                    end else begin
                        cfg_error_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (abort_i) begin
                    state_d = ST_DONE;
                end else if (trigger_i) begin
                    sample_count_d = SAMP_ZERO;
                    state_d        = ST_CAPTURE;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                // A full FIFO outranks both the last sample and an abort.
                if (fifo_full_i) begin
                    full_error_d = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    if (adc_valid_i) begin
                        o_wr_d         = 1'b1;
                        sample_count_d = samp_inc_s;
                        if (samp_inc_s >= cfg_samples) begin
                            segment_count_d = seg_inc_s;
                            if (seg_inc_s >= cfg_segments) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_REARM;
                            end
                        end else begin
                            state_d = ST_CAPTURE;
                        end
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                    // The sample accepted this cycle is still written on abort.
                    if (abort_i) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = state_d;
                    end
                end
            end
            ST_REARM: begin
                if (abort_i) begin
                    state_d = ST_DONE;
                end else if (!trigger_i) begin
                    sample_count_d = SAMP_ZERO;
                    state_d        = ST_ARMED;
                end else begin
                    state_d = ST_REARM;
                end
            end
            ST_DONE: begin
                capture_done_d = 1'b1;
                hold_cnt_d     = {HOLD_W{1'b0}};
                state_d        = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        armed_d = (state_d == ST_ARMED) || (state_d == ST_REARM);
        busy_d  = (state_d != ST_IDLE);
    end

    // State, counters and all outputs are registered; reset clears everything.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            sample_count_q  <= SAMP_ZERO;
            segment_count_q <= 16'd0;
            hold_cnt_q      <= {HOLD_W{1'b0}};
            capture_start_q <= 1'b0;
            capture_done_q  <= 1'b0;
            o_wr_q          <= 1'b0;
            armed_q         <= 1'b0;
            busy_q          <= 1'b0;
            cfg_error_q     <= 1'b0;
            full_error_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            sample_count_q  <= sample_count_d;
            segment_count_q <= segment_count_d;
            hold_cnt_q      <= hold_cnt_d;
            capture_start_q <= capture_start_d;
            capture_done_q  <= capture_done_d;
            o_wr_q          <= o_wr_d;
            armed_q         <= armed_d;
            busy_q          <= busy_d;
            cfg_error_q     <= cfg_error_d;
            full_error_q    <= full_error_d;
        end
    end

    assign capture_start = capture_start_q;
    assign capture_done  = capture_done_q;
    assign O_wr          = o_wr_q;
    assign armed         = armed_q;
    assign busy          = busy_q;
    assign cfg_error     = cfg_error_q;
    assign full_error    = full_error_q;
    assign sample_count  = sample_count_q;
    assign segment_count = segment_count_q;

endmodule

// File: tb/tb_preddr_capture_sequencer.sv
// Bench for preddr_capture_sequencer: vector table, directed multi-cycle
// scenarios and random stimulus, all compared cycle by cycle against a
// behavioural model of the capture sequence.
module tb_preddr_capture_sequencer;

    localparam int CW   = 20;
    localparam int HOLD = 16;

    logic          wr_clk = 1'b0;
    logic          rst = 1'b1, arm = 1'b0, trig = 1'b0, abrt = 1'b0, vld = 1'b0, full = 1'b0;
    logic [CW-1:0] cfg_s = 20'd1;
    logic [15:0]   cfg_g = 16'd1;
    logic          capture_start, capture_done, O_wr, armed, busy, cfg_error, full_error;
    logic [CW-1:0] sample_count;
    logic [15:0]   segment_count;

    preddr_capture_sequencer #(.pCOUNT_WIDTH(CW), .pHOLDOFF(HOLD)) dut (
        .wr_clk(wr_clk), .reset(rst), .arm_i(arm), .trigger_i(trig), .abort_i(abrt),
        .adc_valid_i(vld), .fifo_full_i(full), .cfg_samples(cfg_s), .cfg_segments(cfg_g),
        .capture_start(capture_start), .capture_done(capture_done), .O_wr(O_wr),
        .armed(armed), .busy(busy), .cfg_error(cfg_error), .full_error(full_error),
        .sample_count(sample_count), .segment_count(segment_count)
    );

    always #5 wr_clk = ~wr_clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, n_wr = 0, n_start = 0, n_done = 0, n_adj = 0;
    int last_wr = -1, done_cyc = -1, busy_low = -1;
    logic prev_wr = 1'b0;

    // Behavioural model: a capture session is either waiting for a trigger,
    // waiting for the trigger to drop, sampling, or running down its tail
    // (one cycle to the done pulse, then HOLD cycles of holdoff).
    bit m_busy, m_wt, m_wl, m_cap, m_ferr, m_cerr, m_start, m_done, m_wr;
    int m_tail, m_samp, m_seg;

    task automatic m_finish();
        m_cap = 0; m_wt = 0; m_wl = 0; m_tail = HOLD + 1;
    endtask

    task automatic model_step();
        m_start = 0; m_done = 0; m_wr = 0;
        if (rst) begin
            m_busy = 0; m_wt = 0; m_wl = 0; m_cap = 0; m_ferr = 0; m_cerr = 0;
            m_tail = 0; m_samp = 0; m_seg = 0;
        end else if (m_tail > 0) begin
            if (m_tail == HOLD + 1) m_done = 1;
            m_tail--;
            if (m_tail == 0) m_busy = 0;
        end else if (!m_busy) begin
            if (arm) begin
                if (cfg_s != 0 && cfg_g != 0) begin
                    m_start = 1; m_samp = 0; m_seg = 0; m_ferr = 0; m_cerr = 0;
                    m_busy = 1; m_wt = 1;
                end else begin
                    m_cerr = 1;
                end
            end
        end else if (m_cap) begin
            if (full) begin
                m_ferr = 1; m_finish();
            end else begin
                if (vld) begin
                    m_wr = 1; m_samp++;
                    if (m_samp >= int'(cfg_s)) begin
                        m_seg++; m_cap = 0;
                        if (m_seg >= int'(cfg_g)) m_finish(); else m_wl = 1;
                    end
                end
                if (abrt) m_finish();
            end
        end else if (abrt) begin
            m_finish();
        end else if (m_wt) begin
            if (trig) begin m_wt = 0; m_cap = 1; m_samp = 0; end
        end else if (m_wl) begin
            if (!trig) begin m_wl = 0; m_wt = 1; m_samp = 0; end
        end
    endtask

    function automatic logic [63:0] model_vec();
        return {21'd0, m_start, m_done, m_wr, (m_wt | m_wl), m_busy, m_cerr, m_ferr,
                20'(m_samp), 16'(m_seg)};
    endfunction

    function automatic logic [63:0] dut_vec();
        return {21'd0, capture_start, capture_done, O_wr, armed, busy, cfg_error, full_error,
                sample_count, segment_count};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge wr_clk);
        model_step();
        @(negedge wr_clk);
        cyc++;
        chk("model", dut_vec(), model_vec());
        if (O_wr) begin
            n_wr++;
            if (prev_wr) n_adj++;
            last_wr = cyc;
        end
        prev_wr = O_wr;
        if (capture_start) n_start++;
        if (capture_done) begin n_done++; done_cyc = cyc; end
        if (!busy && done_cyc >= 0 && busy_low < 0) busy_low = cyc;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clr();
        n_wr = 0; n_start = 0; n_done = 0; n_adj = 0;
        last_wr = -1; done_cyc = -1; busy_low = -1;
    endtask

    task automatic quiet();
        rst = 0; arm = 0; trig = 0; abrt = 0; vld = 0; full = 0;
    endtask

    task automatic do_reset();
        quiet(); rst = 1; tick(); rst = 0;
    endtask

    typedef struct {
        logic          rst, arm, trig, abrt, vld, full;
        logic [CW-1:0] s;
        logic [15:0]   g;
        logic [6:0]    flags;   // start, done, wr, armed, busy, cfg_error, full_error
        logic [CW-1:0] e_samp;
        logic [15:0]   e_seg;
    } vec_t;

    function automatic vec_t mk(input logic [5:0] in, input int s, input int g,
                                input logic [6:0] fl, input int es, input int eg);
        vec_t v;
        {v.rst, v.arm, v.trig, v.abrt, v.vld, v.full} = in;
        v.s = 20'(s); v.g = 16'(g); v.flags = fl; v.e_samp = 20'(es); v.e_seg = 16'(eg);
        return v;
    endfunction

    vec_t tbl[15];

    initial begin
        // inputs: rst arm trig abrt vld full
        tbl[0]  = mk(6'b100000, 2, 1, 7'b0000000, 0, 0);
        tbl[1]  = mk(6'b010000, 2, 0, 7'b0000010, 0, 0);  // bad config: cfg_error
        tbl[2]  = mk(6'b010000, 2, 1, 7'b1001100, 0, 0);  // valid arm clears cfg_error
        tbl[3]  = mk(6'b000010, 2, 1, 7'b0001100, 0, 0);  // sample ignored while armed
        tbl[4]  = mk(6'b001000, 2, 1, 7'b0000100, 0, 0);  // trigger -> capture
        tbl[5]  = mk(6'b001010, 2, 1, 7'b0010100, 1, 0);
        tbl[6]  = mk(6'b001000, 2, 1, 7'b0000100, 1, 0);
        tbl[7]  = mk(6'b011010, 2, 1, 7'b0010100, 2, 1);  // last sample, arm ignored
        tbl[8]  = mk(6'b000000, 2, 1, 7'b0100100, 2, 1);  // capture_done after last write
        tbl[9]  = mk(6'b000100, 2, 1, 7'b0000100, 2, 1);  // abort ignored in holdoff
        tbl[10] = mk(6'b110000, 2, 1, 7'b0000000, 0, 0);  // reset wins over arm
        tbl[11] = mk(6'b010000, 3, 2, 7'b1001100, 0, 0);
        tbl[12] = mk(6'b001100, 3, 2, 7'b0000100, 0, 0);  // abort beats trigger
        tbl[13] = mk(6'b000000, 3, 2, 7'b0100100, 0, 0);
        tbl[14] = mk(6'b100000, 3, 2, 7'b0000000, 0, 0);

        for (int i = 0; i < 15; i++) begin
            {rst, arm, trig, abrt, vld, full} = {tbl[i].rst, tbl[i].arm, tbl[i].trig,
                                                 tbl[i].abrt, tbl[i].vld, tbl[i].full};
            cfg_s = tbl[i].s; cfg_g = tbl[i].g;
            tick();
            chk($sformatf("tbl%0d", i), dut_vec(), {21'd0, tbl[i].flags, tbl[i].e_samp, tbl[i].e_seg});
        end

        // Single segment of 5 with continuous valid.
        do_reset(); cfg_s = 20'd5; cfg_g = 16'd1; clr();
        arm = 1; tick(); arm = 0; trig = 1; vld = 1; run(40);
        chk("s5_start", n_start, 1);
        chk("s5_wr", n_wr, 5);
        chk("s5_done", n_done, 1);
        chk("s5_done_lat", done_cyc - last_wr, 1);
        chk("s5_holdoff", busy_low - done_cyc, HOLD);

        // Two segments of 3 with the trigger held high: stall until it drops.
        do_reset(); cfg_s = 20'd3; cfg_g = 16'd2; clr();
        arm = 1; tick(); arm = 0; trig = 1; vld = 1; run(15);
        chk("rearm_wr", n_wr, 3);
        chk("rearm_armed", armed, 1);
        chk("rearm_nodone", n_done, 0);
        trig = 0; tick(); trig = 1; run(30);
        chk("rearm_wr2", n_wr, 6);
        chk("rearm_seg", segment_count, 2);
        chk("rearm_done", n_done, 1);

        // Alternating valid, 4 samples.
        do_reset(); cfg_s = 20'd4; cfg_g = 16'd1; clr();
        arm = 1; tick(); arm = 0; trig = 1; tick();
        for (int i = 0; i < 12; i++) begin vld = (i % 2 == 0); tick(); end
        vld = 0; run(5);
        chk("alt_wr", n_wr, 4);
        chk("alt_adjacent", n_adj, 0);
        chk("alt_samp", sample_count, 4);

        // FIFO full on the third sample of ten.
        do_reset(); cfg_s = 20'd10; cfg_g = 16'd1; clr();
        arm = 1; tick(); arm = 0; trig = 1; tick();
        vld = 1; tick(); tick(); full = 1; tick(); full = 0; vld = 0; run(25);
        chk("full_wr", n_wr, 2);
        chk("full_err", full_error, 1);
        chk("full_done", n_done, 1);

        // Zero segments: rejected arm.
        do_reset(); cfg_s = 20'd5; cfg_g = 16'd0; clr();
        arm = 1; tick(); arm = 0; tick();
        chk("cfg0_start", n_start, 0);
        chk("cfg0_err", cfg_error, 1);
        chk("cfg0_busy", busy, 0);

        // Reset in the middle of a capture, then a normal capture.
        do_reset(); cfg_s = 20'd10; cfg_g = 16'd1; clr();
        arm = 1; tick(); arm = 0; trig = 1; tick(); vld = 1; tick(); tick();
        rst = 1; tick();
        chk("midrst_outs", dut_vec(), 64'd0);
        quiet(); run(20);
        chk("midrst_nodone", n_done, 0);
        cfg_s = 20'd2; clr();
        arm = 1; tick(); arm = 0; trig = 1; vld = 1; run(30);
        chk("midrst_rearm_start", n_start, 1);
        chk("midrst_rearm_wr", n_wr, 2);
        chk("midrst_rearm_done", n_done, 1);

        // Random stimulus against the model.
        do_reset(); cfg_s = 20'd3; cfg_g = 16'd2;
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            arm  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) trig = ~trig;
            abrt = ($urandom_range(0, 31) == 0);
            vld  = ($urandom_range(0, 9) < 6);
            full = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) begin
                cfg_s = 20'($urandom_range(0, 5));
                cfg_g = 16'($urandom_range(0, 3));
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
